ibex_prefetch_buffer_nreq: RTL and testbench
============================================

Name: ibex_prefetch_buffer_nreq

Overview:
Parametrised successor to the two-request instruction prefetch buffer. It sits between the IF stage and the instruction memory or icache bus, and issues sequential word fetches. Outstanding-request depth and FIFO depth are configurable, and it has an integrated word FIFO. Adds a prefetch-throttle mode and occupancy status outputs.

Parameters:
NumReqs, 2, max granted-but-unanswered bus requests (1..4)
FifoDepth, 3, word entries in internal FIFO (>= NumReqs, <= 8)
ResetAll, 1'b0, when 1 all datapath flops (addresses, FIFO data) are reset; control flops are always reset

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
req_i  in  1  core wants fetching
branch_i  in  1  redirect; flush and restart at addr_i
addr_i  in  32  branch target
throttle_i  in  1  1 = limit to one outstanding request
ready_i  in  1  consumer accepts head word
valid_o  out  1  head word valid
rdata_o  out  32  head word data
addr_o  out  32  head word address, word-aligned
err_o  out  1  bus error on head word
instr_req_o  out  1  bus request
instr_gnt_i  in  1  bus grant
instr_addr_o  out  32  bus address, bits [1:0] = 0
instr_rdata_i  in  32  bus read data
instr_err_i  in  1  bus error, qualified by rvalid
instr_rvalid_i  in  1  bus response
busy_o  out  1  request pending or any outstanding
outstanding_o  out  3  granted requests awaiting rvalid
fifo_level_o  out  4  valid FIFO entries

Behaviour:
- Reset: valid_o=0, instr_req_o=0, busy_o=0, outstanding_o=0, fifo_level_o=0. rdata_o, addr_o, err_o, instr_addr_o are 0 if ResetAll, else don't-care.
- Counters:
  - out_cnt: granted requests not yet answered (0..NumReqs).
  - disc_cnt: how many of the oldest out_cnt are discarded (disc_cnt <= out_cnt).
- Live = out_cnt - disc_cnt.
- New request allowed when all of the following hold:
  - req_i=1
  - out_cnt < lim, where lim = throttle_i ? 1 : NumReqs
  - (branch_i ? 0 : fifo_level + live) < FifoDepth
  - no held request is pending
- Bus protocol:
  - Once instr_req_o rises, it and instr_addr_o stay stable until instr_gnt_i.
  - A branch during an ungranted request does not drop or change that request; it is marked discard-on-grant.
  - Grant of a request marked discard increments both out_cnt and disc_cnt.
- Address tracking:
  - fetch_addr: the next word to fetch.
  - On branch, fetch_addr = {addr_i[31:2],2'b00}. When a new request issues in the branch cycle, it uses that address and fetch_addr becomes that address + 4.
  - A new unheld request uses fetch_addr, and fetch_addr advances by 4. Wrap at 2^32 is silent.
  - The held address is captured only for a new request not granted in its issue cycle.
- Branch cycle:
  - disc_cnt := out_cnt, plus 1 if a discarded request is granted that cycle; minus 1 if an rvalid arrives that cycle.
  - FIFO is cleared.
  - ready_i is ignored.
  - The FIFO address pointer is reloaded to the aligned addr_i.
- rvalid handling:
  - out_cnt decrements.
  - If disc_cnt > 0: data dropped, disc_cnt decrements.
  - Else: {rdata, err} pushed to FIFO.
  - Grant and rvalid in the same cycle leave out_cnt unchanged.
- FIFO:
  - Registered entries. A pushed word appears on valid_o the cycle after rvalid; there is no bypass.
  - Pop on valid_o & ready_i. addr_o increments by 4 per pop.
  - Push and pop in the same cycle leave the level unchanged.
  - Overflow is impossible by the space rule; an assertion is required.
- Error: err_o accompanies its word. Fetching continues; the consumer handles the error.
- throttle_i change: existing outstanding requests complete. The new limit gates only new requests.
- busy_o = instr_req_o | (out_cnt != 0).
- Reset mid-transaction clears everything. Responses arriving after reset are out of protocol.
- Assertions:
  - rvalid never arrives with out_cnt == 0.
  - instr_req_o / instr_addr_o are stable while ungranted.

Test Plan:
1. Stream with branch to 0x100, gnt always 1, rvalid 1 cycle later, ready=1 -> instr_addr_o = 0x100, 0x104, 0x108 ...; first valid_o 2 cycles after grant with addr_o=0x100.
2. NumReqs=4, FifoDepth=4, ready=0, rvalid delayed 5 cycles -> exactly 4 grants; fifo_level_o reaches 4; instr_req_o stays 0 until a pop.
3. Branch to 0x200 with 2 outstanding (disc_cnt=2) -> both responses dropped, valid_o stays 0; first pushed word has addr_o=0x200.
4. Request at 0x40 ungranted for 3 cycles, branch to 0x80 in cycle 2 -> instr_addr_o holds 0x40 until grant; its data is dropped; next request is 0x80.
5. throttle_i=1 with NumReqs=3 -> outstanding_o never exceeds 1; deassert throttle -> reaches 3.
6. rvalid with instr_err_i=1 at 0x300 -> err_o=1 with addr_o=0x300; following word at 0x304 has err_o=0.

Source files
------------

// File: rtl/ibex_prefetch_buffer_nreq.sv
`default_nettype none
// ============================================================================
// Module   : ibex_prefetch_buffer_nreq
// Purpose  : Sequential instruction prefetcher. It supports a configurable
//            number of outstanding bus requests, an integrated word FIFO,
//            a throttle mode and occupancy status outputs.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_prefetch_buffer_nreq #(
   parameter int unsigned NumReqs   = 2,
   parameter int unsigned FifoDepth = 3,
   parameter bit          ResetAll  = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic        branch_i,
   input  logic [31:0] addr_i,
   input  logic        throttle_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] rdata_o,
   output logic [31:0] addr_o,
   output logic        err_o,
   output logic        instr_req_o,
   input  logic        instr_gnt_i,
   output logic [31:0] instr_addr_o,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i,
   input  logic        instr_rvalid_i,
   output logic        busy_o,
   output logic [2:0]  outstanding_o,
   output logic [3:0]  fifo_level_o
);

   localparam logic [2:0] c_num_reqs   = 3'(NumReqs);
   localparam logic [3:0] c_fifo_depth = 4'(FifoDepth);

   // Control state (always reset)
   logic [2:0]  r_out_cnt;
   logic [2:0]  r_disc_cnt;
   logic        r_held_valid;
   logic        r_held_disc;
   logic [3:0]  r_level;

   // Datapath state (reset only when ResetAll)
   logic [31:0] r_held_addr;
   logic [31:0] r_fetch_addr;
   logic [31:0] r_head_addr;
   logic [31:0] r_fifo_data [FifoDepth];
   logic        r_fifo_err  [FifoDepth];

   logic [31:0] w_branch_addr;
   logic [31:0] w_new_addr;
   logic [2:0]  w_live;
   logic [2:0]  w_lim;
   logic        w_space;
   logic        w_new_req;
   logic        w_hold_new;
   logic        w_gnt;
   logic        w_gnt_disc;
   logic        w_drop;
   logic        w_push;
   logic        w_pop;
   logic [3:0]  w_wr_idx;
   logic [2:0]  w_out_cnt_d;
   logic [2:0]  w_disc_cnt_d;
   logic [3:0]  w_level_d;
   logic [31:0] w_fetch_addr_d;
   logic [31:0] w_held_addr_d;
   logic [31:0] w_head_addr_d;
   logic [31:0] w_fifo_data_d [FifoDepth];
   logic        w_fifo_err_d  [FifoDepth];
   logic        w_unused_addr_lsb;

   assign w_branch_addr     = {addr_i[31:2], 2'b00};
   assign w_unused_addr_lsb = ^addr_i[1:0];

   // Requests in flight whose data will still be kept
   assign w_live    = r_out_cnt - r_disc_cnt;
   assign w_lim     = throttle_i ? 3'd1 : c_num_reqs;
   // A branch flushes the FIFO and discards every live request, so space is free
   assign w_space   = branch_i ? 1'b1 : ((r_level + {1'b0, w_live}) < c_fifo_depth);
   assign w_new_req = req_i & ~r_held_valid & (r_out_cnt < w_lim) & w_space;
   assign w_new_addr = branch_i ? w_branch_addr : r_fetch_addr;
   assign w_hold_new = w_new_req & ~instr_gnt_i;

   // A held request keeps the bus until granted, even across a branch
   assign instr_req_o  = r_held_valid | w_new_req;
   assign instr_addr_o = r_held_valid ? r_held_addr : w_new_addr;

   assign w_gnt      = instr_req_o & instr_gnt_i;
   // A held request granted in (or after) a branch cycle belongs to the old stream
   assign w_gnt_disc = w_gnt & r_held_valid & (r_held_disc | branch_i);
   assign w_drop     = instr_rvalid_i & (r_disc_cnt != 3'd0);

   assign valid_o  = (r_level != 4'd0);
   assign w_pop    = valid_o & ready_i & ~branch_i;
   assign w_push   = instr_rvalid_i & (r_disc_cnt == 3'd0) & ~branch_i;
   assign w_wr_idx = r_level - {3'b000, w_pop};

   assign rdata_o       = r_fifo_data[0];
   assign err_o         = r_fifo_err[0];
   assign addr_o        = r_head_addr;
   assign busy_o        = instr_req_o | (r_out_cnt != 3'd0);
   assign outstanding_o = r_out_cnt;
   assign fifo_level_o  = r_level;

   // Next values of the outstanding / discard counters and FIFO level
   always_comb begin
      w_out_cnt_d = r_out_cnt + {2'b00, w_gnt} - {2'b00, instr_rvalid_i};
      if (branch_i) begin
         w_disc_cnt_d = r_out_cnt + {2'b00, w_gnt_disc} - {2'b00, instr_rvalid_i};
         w_level_d    = 4'd0;
      end else begin
         w_disc_cnt_d = r_disc_cnt + {2'b00, w_gnt_disc} - {2'b00, w_drop};
         w_level_d    = r_level + {3'b000, w_push} - {3'b000, w_pop};
      end
   end

   // Next values of addresses and FIFO storage (shift-down FIFO, head at entry 0)
   always_comb begin
      w_fetch_addr_d = r_fetch_addr;
      if (w_new_req)     w_fetch_addr_d = w_new_addr + 32'd4;
      else if (branch_i) w_fetch_addr_d = w_branch_addr;
      w_held_addr_d = w_hold_new ? w_new_addr : r_held_addr;
      w_head_addr_d = r_head_addr;
      if (branch_i)   w_head_addr_d = w_branch_addr;
      else if (w_pop) w_head_addr_d = r_head_addr + 32'd4;
      w_fifo_data_d = r_fifo_data;
      w_fifo_err_d  = r_fifo_err;
      if (w_pop) begin
         for (int i = 0; i < FifoDepth - 1; i++) begin
            w_fifo_data_d[i] = r_fifo_data[i+1];
            w_fifo_err_d[i]  = r_fifo_err[i+1];
         end
      end
      if (w_push) begin
         for (int i = 0; i < FifoDepth; i++) begin
            if (4'(i) == w_wr_idx) begin
               w_fifo_data_d[i] = instr_rdata_i;
               w_fifo_err_d[i]  = instr_err_i;
            end
         end
      end
   end

   // Control registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_out_cnt    <= 3'd0;
         r_disc_cnt   <= 3'd0;
         r_held_valid <= 1'b0;
         r_held_disc  <= 1'b0;
         r_level      <= 4'd0;
      end else begin
         r_out_cnt  <= w_out_cnt_d;
         r_disc_cnt <= w_disc_cnt_d;
         r_level    <= w_level_d;
         if (w_hold_new) begin
            r_held_valid <= 1'b1;
            r_held_disc  <= 1'b0;
         end else if (r_held_valid && instr_gnt_i) begin
            r_held_valid <= 1'b0;
            r_held_disc  <= 1'b0;
         end else if (r_held_valid && branch_i) begin
            r_held_disc  <= 1'b1;
         end
      end
   end

   if (ResetAll) begin : g_dp_reset
      // Datapath registers with reset
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_held_addr  <= 32'd0;
            r_fetch_addr <= 32'd0;
            r_head_addr  <= 32'd0;
            for (int i = 0; i < FifoDepth; i++) begin
               r_fifo_data[i] <= 32'd0;
               r_fifo_err[i]  <= 1'b0;
            end
         end else begin
            r_held_addr  <= w_held_addr_d;
            r_fetch_addr <= w_fetch_addr_d;
            r_head_addr  <= w_head_addr_d;
            r_fifo_data  <= w_fifo_data_d;
            r_fifo_err   <= w_fifo_err_d;
         end
      end
   end else begin : g_dp_noreset
      // Datapath registers without reset
      always_ff @(posedge clk_i) begin
         r_held_addr  <= w_held_addr_d;
         r_fetch_addr <= w_fetch_addr_d;
         r_head_addr  <= w_head_addr_d;
         r_fifo_data  <= w_fifo_data_d;
         r_fifo_err   <= w_fifo_err_d;
      end
   end

   a_rvalid_expected : assert property (@(posedge clk_i) disable iff (!rst_ni)
      instr_rvalid_i |-> (r_out_cnt != 3'd0));
   a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (instr_req_o && !instr_gnt_i) |=> (instr_req_o && $stable(instr_addr_o)));
   a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (w_push && !w_pop) |-> (r_level < c_fifo_depth));

endmodule
`default_nettype wire

// File: tb/tb_ibex_prefetch_buffer_nreq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_prefetch_buffer_nreq
// Purpose  : Directed self-checking bench for ibex_prefetch_buffer_nreq.
//            u_dut is NumReqs=4/FifoDepth=4/ResetAll=1, u_dut3 is
//            NumReqs=3/FifoDepth=3/ResetAll=0 (throttle scenario).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibex_prefetch_buffer_nreq;

   logic        clk;
   logic        rst_n;
   int          n_cmp;
   int          n_bad;

   // u_dut stimulus / observation
   logic        req, br, thr, rdy, gnt, rv, rerr;
   logic [31:0] baddr, rdat;
   logic        valid, eout, ireq, busy;
   logic [31:0] dout, aout, iaddr;
   logic [2:0]  outst;
   logic [3:0]  lvl;

   // u_dut3 stimulus / observation
   logic        b_req, b_br, b_thr, b_rdy, b_gnt, b_rv, b_rerr;
   logic [31:0] b_addr, b_rdat;
   logic        b_valid, b_eout, b_ireq, b_busy;
   logic [31:0] b_dout, b_aout, b_iaddr;
   logic [2:0]  b_outst;
   logic [3:0]  b_lvl;

   ibex_prefetch_buffer_nreq #(.NumReqs(4), .FifoDepth(4), .ResetAll(1'b1)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .branch_i(br), .addr_i(baddr),
      .throttle_i(thr), .ready_i(rdy), .valid_o(valid), .rdata_o(dout),
      .addr_o(aout), .err_o(eout), .instr_req_o(ireq), .instr_gnt_i(gnt),
      .instr_addr_o(iaddr), .instr_rdata_i(rdat), .instr_err_i(rerr),
      .instr_rvalid_i(rv), .busy_o(busy), .outstanding_o(outst), .fifo_level_o(lvl)
   );

   ibex_prefetch_buffer_nreq #(.NumReqs(3), .FifoDepth(3), .ResetAll(1'b0)) u_dut3 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .branch_i(b_br), .addr_i(b_addr),
      .throttle_i(b_thr), .ready_i(b_rdy), .valid_o(b_valid), .rdata_o(b_dout),
      .addr_o(b_aout), .err_o(b_eout), .instr_req_o(b_ireq), .instr_gnt_i(b_gnt),
      .instr_addr_o(b_iaddr), .instr_rdata_i(b_rdat), .instr_err_i(b_rerr),
      .instr_rvalid_i(b_rv), .busy_o(b_busy), .outstanding_o(b_outst), .fifo_level_o(b_lvl)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      rst_n = 1'b0;
      req = 0; br = 0; baddr = 0; thr = 0; rdy = 0; gnt = 0; rv = 0; rdat = 0; rerr = 0;
      b_req = 0; b_br = 0; b_addr = 0; b_thr = 0; b_rdy = 0; b_gnt = 0; b_rv = 0;
      b_rdat = 0; b_rerr = 0;
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      chk("rst_valid", valid, 0);  chk("rst_ireq", ireq, 0);   chk("rst_busy", busy, 0);
      chk("rst_outst", outst, 0);  chk("rst_lvl", lvl, 0);     chk("rst_rdata", dout, 0);
      chk("rst_addr", aout, 0);    chk("rst_err", eout, 0);    chk("rst_iaddr", iaddr, 0);
      chk("rst3_valid", b_valid, 0); chk("rst3_ireq", b_ireq, 0); chk("rst3_busy", b_busy, 0);
      chk("rst3_outst", b_outst, 0); chk("rst3_lvl", b_lvl, 0);
      rst_n = 1'b1;
      cyc();

      // ---- 1: streaming after branch to 0x100 ----
      rdy = 1; req = 1; br = 1; baddr = 32'h100; gnt = 1; settle();
      chk("t1_ireq", ireq, 1); chk("t1_iaddr0", iaddr, 32'h100);
      cyc();
      br = 0; baddr = 0; rv = 1; rdat = 32'hD000_0100; settle();
      chk("t1_iaddr1", iaddr, 32'h104); chk("t1_novalid", valid, 0);
      cyc();
      rdat = 32'hD000_0104; settle();
      chk("t1_valid", valid, 1); chk("t1_aout0", aout, 32'h100);
      chk("t1_dout0", dout, 32'hD000_0100); chk("t1_iaddr2", iaddr, 32'h108);
      cyc();
      rdat = 32'hD000_0108; settle();
      chk("t1_aout1", aout, 32'h104); chk("t1_dout1", dout, 32'hD000_0104);
      chk("t1_iaddr3", iaddr, 32'h10C);
      cyc();
      req = 0; gnt = 0; rdat = 32'hD000_010C; settle();
      chk("t1_aout2", aout, 32'h108);
      cyc();
      rv = 0; settle();
      chk("t1_aout3", aout, 32'h10C); chk("t1_dout3", dout, 32'hD000_010C);
      chk("t1_outst", outst, 0);
      cyc();
      settle();
      chk("t1_empty", valid, 0); chk("t1_idle", busy, 0);

      // ---- 2: four outstanding, FIFO fills, no request until a pop ----
      cyc();
      rdy = 0; req = 1; br = 1; baddr = 32'h400; gnt = 1; settle();
      cyc();
      br = 0; settle(); chk("t2_iaddr1", iaddr, 32'h404);
      cyc(); settle(); cyc(); settle(); cyc();
      settle(); chk("t2_full_req", ireq, 0); chk("t2_outst4", outst, 4);
      cyc();
      rv = 1; rdat = 32'hD000_0400; cyc();
      rdat = 32'hD000_0404; settle(); chk("t2_space_req", ireq, 0);
      cyc();
      rdat = 32'hD000_0408; cyc();
      rdat = 32'hD000_040C; cyc();
      rv = 0; settle();
      chk("t2_lvl4", lvl, 4); chk("t2_outst0", outst, 0); chk("t2_lvl_req", ireq, 0);
      chk("t2_valid", valid, 1); chk("t2_aout", aout, 32'h400);
      cyc();
      rdy = 1; settle(); chk("t2_pop_req", ireq, 0);
      cyc();
      rdy = 0; settle();
      chk("t2_resume_req", ireq, 1); chk("t2_resume_addr", iaddr, 32'h410); chk("t2_lvl3", lvl, 3);
      cyc();
      req = 0; br = 1; baddr = 32'h600; rv = 1; rdat = 32'hD000_0410; settle();
      cyc();
      br = 0; rv = 0; settle();
      chk("t2_flush_valid", valid, 0); chk("t2_flush_lvl", lvl, 0);
      chk("t2_flush_outst", outst, 0); chk("t2_flush_busy", busy, 0);

      // ---- 3: branch with two outstanding, both dropped ----
      cyc();
      req = 1; br = 1; baddr = 32'h180; gnt = 1; settle();
      cyc();
      br = 0; settle(); chk("t3_iaddr1", iaddr, 32'h184);
      cyc();
      br = 1; baddr = 32'h200; settle();
      chk("t3_br_req", ireq, 1); chk("t3_br_addr", iaddr, 32'h200);
      cyc();
      br = 0; req = 0; gnt = 0; rv = 1; rdat = 32'hD000_0180; settle();
      chk("t3_outst3", outst, 3);
      cyc();
      rdat = 32'hD000_0184; settle();
      chk("t3_drop0", valid, 0); chk("t3_outst2", outst, 2);
      cyc();
      rdat = 32'hD000_0200; settle(); chk("t3_drop1", valid, 0);
      cyc();
      rv = 0; rdy = 1; settle();
      chk("t3_valid", valid, 1); chk("t3_aout", aout, 32'h200);
      chk("t3_dout", dout, 32'hD000_0200); chk("t3_outst0", outst, 0);
      cyc();
      rdy = 0; settle(); chk("t3_lvl0", lvl, 0);

      // ---- 4: ungranted request held across a branch ----
      cyc();
      req = 1; br = 1; baddr = 32'h40; gnt = 0; settle();
      chk("t4_req", ireq, 1); chk("t4_addr_c0", iaddr, 32'h40);
      cyc();
      br = 0; settle(); chk("t4_addr_c1", iaddr, 32'h40);
      cyc();
      br = 1; baddr = 32'h80; settle();
      chk("t4_addr_c2", iaddr, 32'h40); chk("t4_req_c2", ireq, 1);
      cyc();
      br = 0; gnt = 1; settle(); chk("t4_addr_gnt", iaddr, 32'h40);
      cyc();
      settle(); chk("t4_next_addr", iaddr, 32'h80); chk("t4_outst1", outst, 1);
      cyc();
      req = 0; gnt = 0; rv = 1; rdat = 32'hD000_0040; settle();
      chk("t4_outst2", outst, 2);
      cyc();
      rdat = 32'hD000_0080; settle(); chk("t4_drop", valid, 0);
      cyc();
      rv = 0; rdy = 1; settle();
      chk("t4_valid", valid, 1); chk("t4_aout", aout, 32'h80); chk("t4_dout", dout, 32'hD000_0080);
      cyc();
      rdy = 0; settle(); chk("t4_lvl0", lvl, 0); chk("t4_idle", busy, 0);

      // ---- 6: bus error travels with its word ----
      cyc();
      req = 1; br = 1; baddr = 32'h300; gnt = 1; settle();
      cyc();
      br = 0; rv = 1; rdat = 32'hD000_0300; rerr = 1; settle();
      chk("t6_iaddr1", iaddr, 32'h304);
      cyc();
      req = 0; gnt = 0; rdat = 32'hD000_0304; rerr = 0; rdy = 1; settle();
      chk("t6_valid0", valid, 1); chk("t6_aout0", aout, 32'h300);
      chk("t6_err0", eout, 1); chk("t6_dout0", dout, 32'hD000_0300);
      cyc();
      rv = 0; settle();
      chk("t6_valid1", valid, 1); chk("t6_aout1", aout, 32'h304);
      chk("t6_err1", eout, 0); chk("t6_dout1", dout, 32'hD000_0304);
      cyc();
      rdy = 0; settle(); chk("t6_lvl0", lvl, 0); chk("t6_idle", busy, 0);

      // ---- 5: throttle on NumReqs=3 instance ----
      cyc();
      b_rdy = 1; b_gnt = 1; b_req = 1; b_br = 1; b_addr = 32'h700; b_thr = 1; settle();
      chk("t5_req0", b_ireq, 1); chk("t5_addr0", b_iaddr, 32'h700);
      cyc();
      b_br = 0; b_rv = 1; b_rdat = 32'hD000_0700; settle();
      chk("t5_thr_block", b_ireq, 0); chk("t5_outst1", b_outst, 1);
      cyc();
      b_rv = 0; settle();
      chk("t5_req1", b_ireq, 1); chk("t5_addr1", b_iaddr, 32'h704);
      chk("t5_outst0", b_outst, 0); chk("t5_valid0", b_valid, 1); chk("t5_aout0", b_aout, 32'h700);
      cyc();
      settle(); chk("t5_thr_block2", b_ireq, 0);
      b_thr = 0; settle();
      chk("t5_unthr_req", b_ireq, 1); chk("t5_addr2", b_iaddr, 32'h708);
      cyc();
      settle(); chk("t5_addr3", b_iaddr, 32'h70C);
      cyc();
      b_rv = 1; b_rdat = 32'hD000_0704; settle();
      chk("t5_outst3", b_outst, 3); chk("t5_max_req", b_ireq, 0);
      cyc();
      b_req = 0; b_rdat = 32'hD000_0708; settle();
      chk("t5_valid1", b_valid, 1); chk("t5_aout1", b_aout, 32'h704);
      chk("t5_dout1", b_dout, 32'hD000_0704); chk("t5_err1", b_eout, 0);
      cyc();
      b_rdat = 32'hD000_070C; settle(); chk("t5_aout2", b_aout, 32'h708);
      cyc();
      b_rv = 0; settle(); chk("t5_aout3", b_aout, 32'h70C);
      cyc();
      settle(); chk("t5_lvl0", b_lvl, 0); chk("t5_idle", b_busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
